// File: rtl/matrix_scan_pkg.sv
// matrix_scan_pkg
//   Shared definitions for the matrix scan driver: the scan FSM state
//   encoding and the helper functions that derive chain length and
//   address/counter widths from the matrix geometry.
//   No ports (package).
package matrix_scan_pkg;

    // Scan FSM states. The encoding is also exported on the debug port.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } scan_state_e;

    localparam int DEF_ROWS = 16;
    localparam int DEF_COLS = 16;
    localparam int DEF_DIV  = 499;

    // Shift chain length L: both chains are clocked by one SRCLK, so they
    // are padded to the longer of the two.
    function automatic int scan_len(input int rows, input int cols);
        return (rows > cols) ? rows : cols;
    endfunction

    // Width able to index n items, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// scan_tick
//   Free-running divider producing a one-clock tick every DIV+1 clocks.
//   Ports:
//     CLK1_50 - clock
//     CLR     - synchronous active-high reset (counter to 0, tick low)
//     tick    - registered single-cycle strobe
module scan_tick
    import matrix_scan_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic CLK1_50,
    input  logic CLR,
    output logic tick
);

    localparam int CW = idx_w(DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == CW'(DIV));
        cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLK1_50) begin
        if (CLR) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver
//   Double-buffered LED matrix scanner. Rows of the front bank are shifted
//   out MSB-first on SER_DATA together with a one-hot row select on
//   SER_SEL, both clocked by SRCLK and latched by RCLK. The host writes the
//   back bank and requests a bank exchange, which only happens between
//   frames so the visible image never tears.
//   Ports:
//     CLK1_50, CLR        - clock, synchronous active-high reset
//     wr_en/wr_row/wr_data- back-bank row write (rows >= ROWS ignored)
//     swap_req / swap_ack - bank exchange request / completion pulse
//     frame_start         - pulse when row 0 LOAD is executed
//     SER_DATA, SER_SEL   - pixel and row-select serial streams
//     SRCLK, RCLK         - shared shift clock and latch clock
//     dbg_state_o         - current scan FSM state
//
//   Swap handshake: swap_req is a fire-and-forget single-cycle request; it
//   sets a pending flag and any further requests while pending merge into
//   it. swap_ack pulses for one clock on the edge where the banks actually
//   exchange (the tick that leaves LATCH of the last row). There is no
//   back-pressure: swap_req may be asserted in any cycle.
module matrix_scan_driver
    import matrix_scan_pkg::*;
#(
    parameter int   ROWS     = DEF_ROWS,
    parameter int   COLS     = DEF_COLS,
    parameter int   DIV      = DEF_DIV,
    parameter logic INV_DATA = 1'b0,
    parameter logic INV_SEL  = 1'b0
) (
    input  logic                   CLK1_50,
    input  logic                   CLR,
    input  logic                   wr_en,
    input  logic [idx_w(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]        wr_data,
    input  logic                   swap_req,
    output logic                   swap_ack,
    output logic                   frame_start,
    output logic                   SER_DATA,
    output logic                   SER_SEL,
    output logic                   SRCLK,
    output logic                   RCLK,
    output logic [1:0]             dbg_state_o
);

    localparam int L    = scan_len(ROWS, COLS);
    localparam int RW   = idx_w(ROWS);
    localparam int CNTW = idx_w(2 * L);

    logic tick;

    scan_tick #(.DIV(DIV)) u_tick (
        .CLK1_50 (CLK1_50),
        .CLR     (CLR),
        .tick    (tick)
    );

    scan_state_e     state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [L-1:0]    dsr_q, dsr_d;
    logic [L-1:0]    ssr_q, ssr_d;
    logic            srclk_q, srclk_d;
    logic            rclk_q, rclk_d;
    logic            sdat_q, sdat_d;
    logic            ssel_q, ssel_d;
    logic            ack_q, ack_d;
    logic            fs_q, fs_d;
    logic            front_q, front_d;   // 0: bank0 is displayed
    logic            pend_q, pend_d;

    logic [COLS-1:0] bank0_q [ROWS];
    logic [COLS-1:0] bank1_q [ROWS];
    logic [COLS-1:0] front_row;
    logic            wr_ok;

    always_comb begin
        front_row = front_q ? bank1_q[row_q] : bank0_q[row_q];
        wr_ok     = wr_en && (32'(wr_row) < 32'(ROWS));
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        dsr_d   = dsr_q;
        ssr_d   = ssr_q;
        srclk_d = srclk_q;
        rclk_d  = rclk_q;
        sdat_d  = sdat_q;
        ssel_d  = ssel_q;
        ack_d   = 1'b0;
        fs_d    = 1'b0;
        front_d = front_q;
        pend_d  = pend_q | swap_req;

        if (tick) begin
            case (state_q)
                ST_LOAD: begin
                    // Zero-extension pads the shorter chain at its MSB
                    // end, so those pad bits leave first and both chains
                    // deliver their real bits on the same final SRCLK.
                    dsr_d   = L'(front_row);
                    ssr_d   = L'(1) << row_q;
                    srclk_d = 1'b0;
                    rclk_d  = 1'b0;
                    sdat_d  = INV_DATA;
                    ssel_d  = INV_SEL;
                    cnt_d   = '0;
                    fs_d    = (row_q == '0);
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Even tick: present the next bit with SRCLK low.
                    // Odd tick: raise SRCLK on the stable bit.
                    if (!cnt_q[0]) begin
                        sdat_d  = dsr_q[L-1] ^ INV_DATA;
                        ssel_d  = ssr_q[L-1] ^ INV_SEL;
                        dsr_d   = dsr_q << 1;
                        ssr_d   = ssr_q << 1;
                        srclk_d = 1'b0;
                    end else begin
                        srclk_d = 1'b1;
                    end
                    if (cnt_q == CNTW'(2 * L - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_LATCH;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
                ST_LATCH: begin
                    srclk_d = 1'b0;
                    sdat_d  = INV_DATA;
                    ssel_d  = INV_SEL;
                    if (!cnt_q[0]) begin
                        rclk_d = 1'b1;
                        cnt_d  = CNTW'(1);
                    end else begin
                        rclk_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                        if (row_q == RW'(ROWS - 1)) begin
                            row_d = '0;
                            // Frame boundary: the only place the banks may
                            // exchange. A request arriving on this same
                            // clock is absorbed by the swap it coincides with.
                            if (pend_q) begin
                                front_d = ~front_q;
                                pend_d  = 1'b0;
                                ack_d   = 1'b1;
                            end
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge CLK1_50) begin
        if (CLR) begin
            state_q <= ST_LOAD;
            row_q   <= '0;
            cnt_q   <= '0;
            dsr_q   <= '0;
            ssr_q   <= '0;
            srclk_q <= 1'b0;
            rclk_q  <= 1'b0;
            sdat_q  <= INV_DATA;
            ssel_q  <= INV_SEL;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
            front_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            dsr_q   <= dsr_d;
            ssr_q   <= ssr_d;
            srclk_q <= srclk_d;
            rclk_q  <= rclk_d;
            sdat_q  <= sdat_d;
            ssel_q  <= ssel_d;
            ack_q   <= ack_d;
            fs_q    <= fs_d;
            front_q <= front_d;
            pend_q  <= pend_d;
        end
    end

    // Writes target the bank that is back before this edge (front_q is the
    // pre-edge value), so a write landing on the swap edge becomes visible
    // in the frame that follows.
    always_ff @(posedge CLK1_50) begin
        if (CLR) begin
            for (int i = 0; i < ROWS; i++) begin
                bank0_q[i] <= '0;
                bank1_q[i] <= '0;
            end
        end else if (wr_ok) begin
            if (front_q) begin
                bank0_q[wr_row] <= wr_data;
            end else begin
                bank1_q[wr_row] <= wr_data;
            end
        end
    end

    assign swap_ack    = ack_q;
    assign frame_start = fs_q;
    assign SER_DATA    = sdat_q;
    assign SER_SEL     = ssel_q;
    assign SRCLK       = srclk_q;
    assign RCLK        = rclk_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb_matrix_scan_driver
//   Bench for matrix_scan_driver. Three instances share clock and reset:
//     0: 4x4, DIV=1, non-inverted (main scenarios)
//     1: 4x4, DIV=1, INV_DATA=INV_SEL=1 (inversion)
//     2: 5 rows x 4 cols, DIV=1 (out-of-range write, padded data chain)
//   Expected serial bits {SER_DATA,SER_SEL} are pushed from a bank model
//   and popped on every SRCLK rise of the monitored instance.
module tb_matrix_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic       wr_en0, wr_en1, wr_en2;
    logic [1:0] wr_row0, wr_row1;
    logic [2:0] wr_row2;
    logic [3:0] wr_data0, wr_data1, wr_data2;
    logic       swap0, swap1, swap2;

    logic       sd  [3];
    logic       ss  [3];
    logic       sc  [3];
    logic       rc  [3];
    logic       ack [3];
    logic       fs  [3];
    logic [1:0] dbg [3];

    matrix_scan_driver #(.ROWS(4), .COLS(4), .DIV(1), .INV_DATA(1'b0), .INV_SEL(1'b0)) u_dut (
        .CLK1_50(clk), .CLR(clr), .wr_en(wr_en0), .wr_row(wr_row0), .wr_data(wr_data0),
        .swap_req(swap0), .swap_ack(ack[0]), .frame_start(fs[0]),
        .SER_DATA(sd[0]), .SER_SEL(ss[0]), .SRCLK(sc[0]), .RCLK(rc[0]), .dbg_state_o(dbg[0])
    );

    matrix_scan_driver #(.ROWS(4), .COLS(4), .DIV(1), .INV_DATA(1'b1), .INV_SEL(1'b1)) u_inv (
        .CLK1_50(clk), .CLR(clr), .wr_en(wr_en1), .wr_row(wr_row1), .wr_data(wr_data1),
        .swap_req(swap1), .swap_ack(ack[1]), .frame_start(fs[1]),
        .SER_DATA(sd[1]), .SER_SEL(ss[1]), .SRCLK(sc[1]), .RCLK(rc[1]), .dbg_state_o(dbg[1])
    );

    matrix_scan_driver #(.ROWS(5), .COLS(4), .DIV(1), .INV_DATA(1'b0), .INV_SEL(1'b0)) u_odd (
        .CLK1_50(clk), .CLR(clr), .wr_en(wr_en2), .wr_row(wr_row2), .wr_data(wr_data2),
        .swap_req(swap2), .swap_ack(ack[2]), .frame_start(fs[2]),
        .SER_DATA(sd[2]), .SER_SEL(ss[2]), .SRCLK(sc[2]), .RCLK(rc[2]), .dbg_state_o(dbg[2])
    );

    // Monitored-instance view
    logic [1:0] mon;
    logic       m_sd, m_ss, m_sc, m_fs;
    assign m_sd = sd[mon];
    assign m_ss = ss[mon];
    assign m_sc = sc[mon];
    assign m_fs = fs[mon];

    // Scoreboard and models
    logic [1:0] exp_q[$];
    logic [3:0] exp_frame [8];
    logic [3:0] front_m [4];
    logic [3:0] back_m  [4];

    int checks   = 0;
    int failures = 0;
    int ack_cnt [3];

    initial begin
        for (int i = 0; i < 3; i++) ack_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ack[i] === 1'b1) ack_cnt[i] = ack_cnt[i] + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic model_swap();
        logic [3:0] t;
        for (int i = 0; i < 4; i++) begin
            t = front_m[i]; front_m[i] = back_m[i]; back_m[i] = t;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            front_m[i] = '0; back_m[i] = '0;
        end
    endtask

    task automatic load_exp_from_front();
        for (int i = 0; i < 8; i++) exp_frame[i] = (i < 4) ? front_m[i] : 4'd0;
    endtask

    // Expected bit stream of one frame, MSB-first, shorter chain padded at MSB end.
    task automatic push_frame(input int rows, input int cols, input logic inv);
        int l;
        int b;
        logic d, s;
        l = (rows > cols) ? rows : cols;
        for (int r = 0; r < rows; r++) begin
            for (int k = 0; k < l; k++) begin
                b = l - 1 - k;
                d = (b < cols) ? exp_frame[r][b] : 1'b0;
                s = (b == r);
                exp_q.push_back({d ^ inv, s ^ inv});
            end
        end
    endtask

    task automatic wait_fs(output int w);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (m_fs !== 1'b1 && w < 400);
        checks++;
        if (m_fs !== 1'b1) begin
            failures++;
            $display("FAIL frame_start_wait: waited %0d clocks, frame_start not seen", w);
        end
    endtask

    task automatic wait_ack(input int inst, input int limit, output int w);
        w = 0;
        while (ack[inst] !== 1'b1 && w < limit) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (ack[inst] !== 1'b1) begin
            failures++;
            $display("FAIL swap_ack_wait: inst %0d no swap_ack within %0d clocks", inst, limit);
        end
    endtask

    // Waits for frame_start, then pops/compares one entry per SRCLK rise.
    task automatic capture_frame(input int nbits, input logic chk_data_hi, output int waited);
        logic       prev;
        logic       rose;
        logic [1:0] want;
        int         w;
        wait_fs(waited);
        if (m_fs !== 1'b1) begin
            exp_q.delete();
            return;
        end
        prev = m_sc;
        for (int i = 0; i < nbits; i++) begin
            rose = 1'b0;
            w    = 0;
            while (!rose && w < 60) begin
                @(negedge clk);
                w++;
                if (chk_data_hi) begin
                    checks++;
                    if (m_sd !== 1'b1) begin
                        failures++;
                        $display("FAIL ser_data_const: bit %0d got %b want 1", i, m_sd);
                    end
                end
                rose = (m_sc === 1'b1) && (prev !== 1'b1);
                prev = m_sc;
            end
            want = exp_q.pop_front();
            checks++;
            if (!rose) begin
                failures++;
                $display("FAIL srclk_rise_wait: bit %0d no SRCLK rise within 60 clocks", i);
            end else if ({m_sd, m_ss} !== want) begin
                failures++;
                $display("FAIL serial_bit: inst %0d bit %0d got data/sel %b want %b", mon, i, {m_sd, m_ss}, want);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int w;
        logic [5:0] got, want;
        clr = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            got  = {sc[i], rc[i], sd[i], ss[i], ack[i], fs[i]};
            want = {1'b0, 1'b0, (i == 1), (i == 1), 1'b0, 1'b0};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_outputs: inst %0d got srclk/rclk/sd/ss/ack/fs %b want %b", i, got, want);
            end
            checks++;
            if (dbg[i] !== 2'd0) begin
                failures++;
                $display("FAIL reset_state: inst %0d got %0d want 0", i, dbg[i]);
            end
        end
        clr = 1'b0;
        mon = 2'd0;
        wait_fs(w);
        checks++;
        if (w < 1 || w > 4) begin
            failures++;
            $display("FAIL first_frame_start: got %0d clocks after release want 1..4", w);
        end
        wait_fs(w);
        checks++;
        if (w != 88) begin
            failures++;
            $display("FAIL frame_period: got %0d clocks want 88", w);
        end
    endtask

    task automatic test_basic_display();
        int w;
        int a0;
        mon = 2'd0;
        a0  = ack_cnt[0];
        wr_en0 = 1'b1; wr_row0 = 2'd2; wr_data0 = 4'b1010;
        back_m[2] = 4'b1010;
        @(negedge clk);
        wr_en0 = 1'b0; swap0 = 1'b1;
        @(negedge clk);
        swap0 = 1'b0;
        wait_ack(0, 200, w);
        model_swap();
        load_exp_from_front();
        push_frame(4, 4, 1'b0);
        capture_frame(16, 1'b0, w);
        checks++;
        if (w != 2) begin
            failures++;
            $display("FAIL ack_to_frame_start: got %0d clocks want 2", w);
        end
        checks++;
        if (ack_cnt[0] - a0 != 1) begin
            failures++;
            $display("FAIL basic_ack_count: got %0d want 1", ack_cnt[0] - a0);
        end
    endtask

    task automatic test_double_swap();
        int w;
        int a0;
        int gap;
        mon = 2'd0;
        wait_fs(w);
        a0 = ack_cnt[0];
        @(negedge clk);
        wr_en0 = 1'b1; wr_row0 = 2'd0; wr_data0 = 4'b0110;
        back_m[0] = 4'b0110;
        @(negedge clk);
        wr_en0 = 1'b0; swap0 = 1'b1;
        @(negedge clk);
        swap0 = 1'b0;
        gap = $urandom_range(2, 20);
        repeat (gap) @(negedge clk);
        swap0 = 1'b1;
        @(negedge clk);
        swap0 = 1'b0;
        wait_ack(0, 200, w);
        model_swap();
        for (int f = 0; f < 2; f++) begin
            load_exp_from_front();
            push_frame(4, 4, 1'b0);
            capture_frame(16, 1'b0, w);
        end
        checks++;
        if (ack_cnt[0] - a0 != 1) begin
            failures++;
            $display("FAIL double_swap_ack_count: got %0d want 1", ack_cnt[0] - a0);
        end
    endtask

    task automatic test_boundary_write();
        int w;
        mon = 2'd0;
        wait_fs(w);
        @(negedge clk);
        swap0 = 1'b1;
        @(negedge clk);
        swap0 = 1'b0;
        repeat (83) @(negedge clk);
        // This write is sampled on the same edge that performs the swap.
        wr_en0 = 1'b1; wr_row0 = 2'd1; wr_data0 = 4'b1100;
        @(negedge clk);
        wr_en0 = 1'b0;
        checks++;
        if (ack[0] !== 1'b1) begin
            failures++;
            $display("FAIL swap_edge_align: swap_ack got %b want 1", ack[0]);
        end
        back_m[1] = 4'b1100;
        model_swap();
        load_exp_from_front();
        push_frame(4, 4, 1'b0);
        capture_frame(16, 1'b0, w);
        checks++;
        if (w != 2) begin
            failures++;
            $display("FAIL boundary_frame_start: got %0d clocks want 2", w);
        end
    endtask

    task automatic test_reset_mid_shift();
        int w;
        int n;
        logic prev;
        logic [6:0] got;
        mon = 2'd0;
        wait_fs(w);
        n = 0; w = 0; prev = 1'b0;
        while (n < 6 && w < 100) begin
            @(negedge clk);
            w++;
            if (m_sc === 1'b1 && prev !== 1'b1) n++;
            prev = m_sc;
        end
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL mid_shift_rises: got %0d rises want 6", n);
        end
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        got = {sc[0], rc[0], sd[0], ss[0], ack[0], fs[0], (dbg[0] == 2'd0)};
        checks++;
        if (got !== 7'b0000001) begin
            failures++;
            $display("FAIL mid_shift_reset: got srclk/rclk/sd/ss/ack/fs/load %b want 0000001", got);
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
        clr = 1'b0;
        model_clear();
        load_exp_from_front();
        push_frame(4, 4, 1'b0);
        capture_frame(16, 1'b0, w);
        checks++;
        if (w < 1 || w > 4) begin
            failures++;
            $display("FAIL restart_frame_start: got %0d clocks want 1..4", w);
        end
    endtask

    task automatic test_inversion();
        int w;
        mon = 2'd1;
        for (int i = 0; i < 8; i++) exp_frame[i] = 4'd0;
        push_frame(4, 4, 1'b1);
        capture_frame(16, 1'b1, w);
    endtask

    task automatic test_ignored_write();
        int w;
        mon = 2'd2;
        @(negedge clk);
        wr_en2 = 1'b1; wr_row2 = 3'd5; wr_data2 = 4'b1111;
        @(negedge clk);
        wr_row2 = 3'd4; wr_data2 = 4'b0011;
        @(negedge clk);
        wr_en2 = 1'b0; swap2 = 1'b1;
        @(negedge clk);
        swap2 = 1'b0;
        wait_ack(2, 400, w);
        for (int i = 0; i < 8; i++) exp_frame[i] = 4'd0;
        exp_frame[4] = 4'b0011;
        push_frame(5, 4, 1'b0);
        capture_frame(25, 1'b0, w);
        checks++;
        if (w != 2) begin
            failures++;
            $display("FAIL odd_frame_start: got %0d clocks want 2", w);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        clr = 1'b1;
        wr_en0 = 1'b0; wr_row0 = '0; wr_data0 = '0; swap0 = 1'b0;
        wr_en1 = 1'b0; wr_row1 = '0; wr_data1 = '0; swap1 = 1'b0;
        wr_en2 = 1'b0; wr_row2 = '0; wr_data2 = '0; swap2 = 1'b0;
        mon = 2'd0;
        model_clear();
        for (int i = 0; i < 8; i++) exp_frame[i] = 4'd0;

        test_reset();
        test_basic_display();
        test_double_swap();
        test_boundary_write();
        test_reset_mid_shift();
        test_inversion();
        test_ignored_write();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
